// File: rtl/am_sample_scheduler_if.sv
// rtl/am_sample_scheduler_if.sv - FIFO-read bus shared by the two sample sources and the modulator
interface am_sample_scheduler_if #(
    parameter int SAMPLE_WIDTH = 8
);
    logic [SAMPLE_WIDTH-1:0] a_data;
    logic                    a_empty;
    logic                    a_rd;
    logic [SAMPLE_WIDTH-1:0] b_data;
    logic                    b_empty;
    logic                    b_rd;
    logic [SAMPLE_WIDTH-1:0] mod_sample;
    logic                    mod_empty;
    logic                    mod_read;
    logic                    mod_src;

    modport master (
        input  a_data, a_empty, b_data, b_empty, mod_read,
        output a_rd, b_rd, mod_sample, mod_empty, mod_src
    );

    modport slave (
        output a_data, a_empty, b_data, b_empty, mod_read,
        input  a_rd, b_rd, mod_sample, mod_empty, mod_src
    );
endinterface

// File: rtl/am_sample_scheduler.sv
// rtl/am_sample_scheduler.sv - per-sample A/B source scheduler presenting a depth-1 FIFO to the modulator
module am_sample_scheduler #(
    parameter int SAMPLE_WIDTH   = 8,
    parameter int UNDERRUN_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [1:0]                mode,
    am_sample_scheduler_if.master     bus,
    output logic [UNDERRUN_WIDTH-1:0] underrun_count
);

    typedef enum logic [1:0] {IDLE, REQ, CAP, FULL} state_t;

    state_t                  state, next_state;
    logic                    a_rd_q, b_rd_q;
    logic [SAMPLE_WIDTH-1:0] stage_data;
    logic                    stage_valid;
    logic                    grant;
    logic                    last_grant;
    logic                    starve_d;
    logic [SAMPLE_WIDTH-1:0] mod_sample_q;
    logic                    mod_src_q;
    logic [UNDERRUN_WIDTH-1:0] underrun_q;

    logic pick_ok, pick_src, starve;

    // Source selection is only consumed while in IDLE.
    always_comb begin
        pick_ok  = 1'b0;
        pick_src = 1'b0;
        case (mode)
            2'd0: begin
                pick_ok  = ~bus.a_empty;
                pick_src = 1'b0;
            end
            2'd1: begin
                pick_ok  = ~bus.b_empty;
                pick_src = 1'b1;
            end
            2'd2: begin
                if (last_grant ? ~bus.a_empty : ~bus.b_empty) begin
                    pick_ok  = 1'b1;
                    pick_src = ~last_grant;
                end else if (last_grant ? ~bus.b_empty : ~bus.a_empty) begin
                    pick_ok  = 1'b1;
                    pick_src = last_grant;
                end
            end
            default: begin
                if (~bus.a_empty) begin
                    pick_ok  = 1'b1;
                    pick_src = 1'b0;
                end else if (~bus.b_empty) begin
                    pick_ok  = 1'b1;
                    pick_src = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        next_state = state;
        starve     = 1'b0;
        case (state)
            IDLE: begin
                starve = enable & ~pick_ok;
                if (enable && pick_ok) next_state = REQ;
            end
            REQ:  next_state = CAP;
            CAP:  next_state = FULL;
            FULL: if (bus.mod_read) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            a_rd_q       <= 1'b0;
            b_rd_q       <= 1'b0;
            stage_data   <= '0;
            stage_valid  <= 1'b0;
            grant        <= 1'b0;
            last_grant   <= 1'b1;
            starve_d     <= 1'b0;
            mod_sample_q <= '0;
            mod_src_q    <= 1'b0;
            underrun_q   <= '0;
        end else begin
            state    <= next_state;
            starve_d <= starve;
            a_rd_q   <= 1'b0;
            b_rd_q   <= 1'b0;
            if (state == IDLE && next_state == REQ) begin
                grant  <= pick_src;
                a_rd_q <= ~pick_src;
                b_rd_q <= pick_src;
            end
            // Source FIFOs are non-FWFT: data is valid the cycle after the rd pulse.
            if (state == CAP) begin
                stage_data  <= grant ? bus.b_data : bus.a_data;
                stage_valid <= 1'b1;
                last_grant  <= grant;
            end
            if (state == FULL && bus.mod_read) begin
                mod_sample_q <= stage_data;
                mod_src_q    <= grant;
                stage_valid  <= 1'b0;
            end
            if (starve && !starve_d && underrun_q != {UNDERRUN_WIDTH{1'b1}})
                underrun_q <= underrun_q + 1'b1;
        end
    end

    assign bus.a_rd       = a_rd_q;
    assign bus.b_rd       = b_rd_q;
    assign bus.mod_sample = mod_sample_q;
    assign bus.mod_empty  = ~stage_valid;
    assign bus.mod_src    = mod_src_q;
    assign underrun_count = underrun_q;

endmodule

// File: tb/tb_am_sample_scheduler.sv
// tb/tb_am_sample_scheduler.sv - directed bench for am_sample_scheduler
module tb_am_sample_scheduler;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [1:0] mode;
    logic [3:0] underrun_count;

    am_sample_scheduler_if #(.SAMPLE_WIDTH(8)) bus ();

    am_sample_scheduler #(.SAMPLE_WIDTH(8), .UNDERRUN_WIDTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .mode           (mode),
        .bus            (bus),
        .underrun_count (underrun_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] a_mem [16];
    logic [7:0] b_mem [16];
    int a_wr = 0, a_rdp = 0, b_wr = 0, b_rdp = 0;
    int rd_cnt = 0;
    logic prev_rd = 1'b0;
    logic viol = 1'b0;

    assign bus.a_empty = (a_wr == a_rdp);
    assign bus.b_empty = (b_wr == b_rdp);

    always @(posedge clk) begin
        if (bus.a_rd) begin
            bus.a_data <= a_mem[a_rdp % 16];
            a_rdp      <= a_rdp + 1;
        end
        if (bus.b_rd) begin
            bus.b_data <= b_mem[b_rdp % 16];
            b_rdp      <= b_rdp + 1;
        end
        if (bus.a_rd || bus.b_rd) rd_cnt <= rd_cnt + 1;
        if ((bus.a_rd && bus.b_rd) || ((bus.a_rd || bus.b_rd) && prev_rd)) viol <= 1'b1;
        prev_rd <= bus.a_rd | bus.b_rd;
    end

    int checks = 0;
    int errors = 0;
    int base;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_a(input logic [7:0] d);
        a_mem[a_wr % 16] = d;
        a_wr++;
    endtask

    task automatic push_b(input logic [7:0] d);
        b_mem[b_wr % 16] = d;
        b_wr++;
    endtask

    task automatic read_one(input string tag, input logic [7:0] exp_d, input logic exp_s);
        int n;
        n = 0;
        while (bus.mod_empty !== 1'b0 && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_ready"}, {31'd0, bus.mod_empty}, 32'd0);
        bus.mod_read = 1'b1;
        step();
        bus.mod_read = 1'b0;
        chk({tag, "_data"}, {24'd0, bus.mod_sample}, {24'd0, exp_d});
        chk({tag, "_src"}, {31'd0, bus.mod_src}, {31'd0, exp_s});
        chk({tag, "_empty"}, {31'd0, bus.mod_empty}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_a_rd"}, {31'd0, bus.a_rd}, 32'd0);
        chk({tag, "_b_rd"}, {31'd0, bus.b_rd}, 32'd0);
        chk({tag, "_sample"}, {24'd0, bus.mod_sample}, 32'd0);
        chk({tag, "_src"}, {31'd0, bus.mod_src}, 32'd0);
        chk({tag, "_empty"}, {31'd0, bus.mod_empty}, 32'd1);
        chk({tag, "_underrun"}, {28'd0, underrun_count}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b1;
        mode = 2'd0;
        bus.mod_read = 1'b0;

        // Mode 0 fetch timing with A = {10, 20}
        push_a(8'h10);
        push_a(8'h20);
        repeat (3) step();
        check_reset_outputs("rst0");
        rst = 1'b0;
        step();                                     // cycle 1
        chk("t1_a_rd_c1", {31'd0, bus.a_rd}, 32'd1);
        chk("t1_b_rd_c1", {31'd0, bus.b_rd}, 32'd0);
        step();                                     // cycle 2
        chk("t1_a_rd_c2", {31'd0, bus.a_rd}, 32'd0);
        chk("t1_empty_c2", {31'd0, bus.mod_empty}, 32'd1);
        step();                                     // cycle 3
        chk("t1_empty_c3", {31'd0, bus.mod_empty}, 32'd0);
        step();                                     // cycle 4
        step();                                     // cycle 5
        bus.mod_read = 1'b1;
        step();                                     // cycle 6
        bus.mod_read = 1'b0;
        chk("t1_sample_c6", {24'd0, bus.mod_sample}, 32'h10);
        chk("t1_src_c6", {31'd0, bus.mod_src}, 32'd0);
        chk("t1_empty_c6", {31'd0, bus.mod_empty}, 32'd1);
        step();                                     // cycle 7: refill pulse
        chk("t1_a_rd_c7", {31'd0, bus.a_rd}, 32'd1);
        read_one("t1_w2", 8'h20, 1'b0);

        // Round-robin
        rst = 1'b1;
        mode = 2'd2;
        push_a(8'hA1); push_a(8'hA2);
        push_b(8'hB1); push_b(8'hB2);
        step(); step();
        rst = 1'b0;
        read_one("rr0", 8'hA1, 1'b0);
        read_one("rr1", 8'hB1, 1'b1);
        read_one("rr2", 8'hA2, 1'b0);
        read_one("rr3", 8'hB2, 1'b1);

        // A priority with B fallback
        rst = 1'b1;
        mode = 2'd3;
        push_b(8'h55);
        push_b(8'h66);
        step(); step();
        rst = 1'b0;
        step();                                     // cycle 1: B fetch in flight
        chk("p_b_rd", {31'd0, bus.b_rd}, 32'd1);
        push_a(8'h77);
        read_one("p0", 8'h55, 1'b1);
        read_one("p1", 8'h77, 1'b0);
        read_one("p2", 8'h66, 1'b1);

        // Starvation counting and saturation (4-bit counter)
        rst = 1'b1;
        mode = 2'd0;
        step(); step();
        rst = 1'b0;
        step();
        chk("u_startup", {28'd0, underrun_count}, 32'd1);
        repeat (3) step();
        chk("u_hold", {28'd0, underrun_count}, 32'd1);
        push_a(8'h33);
        read_one("u_w", 8'h33, 1'b0);
        step();
        chk("u_second", {28'd0, underrun_count}, 32'd2);
        for (int i = 0; i < 13; i++) begin
            enable = 1'b0; step();
            enable = 1'b1; step();
        end
        chk("u_reach_max", {28'd0, underrun_count}, 32'd15);
        for (int i = 0; i < 6; i++) begin
            enable = 1'b0; step();
            enable = 1'b1; step();
        end
        chk("u_saturated", {28'd0, underrun_count}, 32'd15);

        // enable dropped during REQ
        rst = 1'b1;
        push_a(8'h44);
        push_a(8'h45);
        step(); step();
        base = rd_cnt;
        rst = 1'b0;
        step();                                     // cycle 1: REQ
        chk("e_req_rd", {31'd0, bus.a_rd}, 32'd1);
        enable = 1'b0;
        read_one("e_w", 8'h44, 1'b0);
        repeat (5) step();
        chk("e_no_rd", rd_cnt - base, 32'd1);
        chk("e_still_empty", {31'd0, bus.mod_empty}, 32'd1);
        enable = 1'b1;
        read_one("e_resume", 8'h45, 1'b0);

        // mod_read while empty is ignored
        base = rd_cnt;
        bus.mod_read = 1'b1;
        repeat (3) step();
        chk("v_idle_sample", {24'd0, bus.mod_sample}, 32'h45);
        chk("v_idle_empty", {31'd0, bus.mod_empty}, 32'd1);
        bus.mod_read = 1'b0;
        step();
        chk("v_idle_no_rd", rd_cnt - base, 32'd0);
        push_a(8'h99);
        bus.mod_read = 1'b1;
        step();                                     // REQ
        chk("v_req_sample", {24'd0, bus.mod_sample}, 32'h45);
        chk("v_req_empty", {31'd0, bus.mod_empty}, 32'd1);
        step();                                     // CAP
        bus.mod_read = 1'b0;
        chk("v_cap_sample", {24'd0, bus.mod_sample}, 32'h45);
        read_one("v_w", 8'h99, 1'b0);

        // rst during CAP
        push_a(8'hAB);
        step();                                     // REQ
        step();                                     // CAP
        rst = 1'b1;
        step();
        check_reset_outputs("rst_cap");
        rst = 1'b0;
        step(); step();

        chk("proto_rd_pulses", {31'd0, viol}, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
